// File: rtl/led_chaser_pkg.sv
// Shared constants for the LED chaser: step-mode encodings and PWM counter width.
package led_pkg;

    localparam logic [1:0] MODE_ROTL   = 2'b00;
    localparam logic [1:0] MODE_ROTR   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam int PWM_W = 4;

endpackage

// File: rtl/led_chaser_tick_divider.sv
// Clock divider: counts 0..DIV-1 while enabled and pulses tick on the wrap cycle.
module tick_divider #(
    parameter int DIV   = 1200000,
    parameter int DIV_W = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    logic [DIV_W-1:0] cnt;
    logic             at_top;

    assign at_top = (cnt == DIV_W'(DIV - 1));
    assign tick   = enable && at_top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= at_top ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_chaser.sv
// LED chaser top: one-hot pattern stepped by a divided tick (rotate/bounce/hold).
// Optional brightness PWM on the LED outputs when LED_CHASER_PWM_EN is defined.
module led_chaser
    import led_pkg::*;
#(
    parameter int N_LEDS = 4,
    parameter int DIV    = 1200000,
    parameter int DIV_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [PWM_W-1:0]  duty,
    output logic [N_LEDS-1:0] leds,
    output logic              tick,
    output logic              led_pwr
);

    logic [N_LEDS-1:0] pat, pat_nxt;
    logic              dir, dir_nxt, dir_eff;

    tick_divider #(.DIV(DIV), .DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // A single LED never moves, so all modes collapse to hold for N_LEDS == 1.
    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        dir_eff = dir;
        if (tick && (N_LEDS > 1)) begin
            case (mode)
                MODE_ROTL: pat_nxt = (pat << 1) | (pat >> (N_LEDS - 1));
                MODE_ROTR: pat_nxt = (pat >> 1) | (pat << (N_LEDS - 1));
                MODE_BOUNCE: begin
                    // Endpoints override the stored direction so entry from a rotate mode never walks off.
                    if (pat[N_LEDS-1])  dir_eff = 1'b1;
                    else if (pat[0])    dir_eff = 1'b0;
                    pat_nxt = dir_eff ? (pat >> 1) : (pat << 1);
                    if (pat_nxt[N_LEDS-1])  dir_nxt = 1'b1;
                    else if (pat_nxt[0])    dir_nxt = 1'b0;
                    else                    dir_nxt = dir_eff;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat <= N_LEDS'(1);
            dir <= 1'b0;
        end else begin
            pat <= pat_nxt;
            dir <= dir_nxt;
        end
    end

    assign led_pwr = 1'b1;

`ifdef LED_CHASER_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    assign leds = pat & {N_LEDS{pwm_cnt < duty}};
`else
    logic unused_duty;

    assign unused_duty = ^duty;
    assign leds        = pat;
`endif

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser with N_LEDS=4, DIV=4.
module tb_led_chaser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] duty;
    logic [3:0] leds;
    logic       tick;
    logic       led_pwr;

    int compared = 0;
    int mismatched = 0;

    led_chaser #(.N_LEDS(4), .DIV(4), .DIV_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .mode    (mode),
        .duty    (duty),
        .leds    (leds),
        .tick    (tick),
        .led_pwr (led_pwr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits out one full step: tick high on the 3rd edge, new pattern after the 4th.
    task automatic step_expect(input string tag, input logic [3:0] exp_leds, input logic [3:0] prev_leds);
        cyc(3);
        chk({tag, "_tick"}, 32'(tick), 32'd1);
        chk({tag, "_pre"}, 32'(leds), 32'(prev_leds));
        cyc(1);
        chk({tag, "_leds"}, 32'(leds), 32'(exp_leds));
        chk({tag, "_tick0"}, 32'(tick), 32'd0);
    endtask

    // Asynchronous reset mid-cycle, then release just after an edge with enable=1.
    task automatic hard_reset(input logic [1:0] md);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_leds", 32'(leds), 32'h1);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pwr", 32'(led_pwr), 32'd1);
        @(posedge clk);
        #1;
        mode   = md;
        rst_n  = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'b00;
        duty   = 4'd0;
        cyc(2);
        chk("init_leds", 32'(leds), 32'h1);
        chk("init_tick", 32'(tick), 32'd0);
        chk("init_pwr", 32'(led_pwr), 32'd1);

        // rotate-left
        hard_reset(2'b00);
        step_expect("rotl1", 4'b0010, 4'b0001);
        step_expect("rotl2", 4'b0100, 4'b0010);
        step_expect("rotl3", 4'b1000, 4'b0100);
        step_expect("rotl4", 4'b0001, 4'b1000);
        // mode toggled between ticks has no effect
        cyc(1);
        mode = 2'b01;
        cyc(1);
        mode = 2'b00;
        cyc(1);
        chk("glitch_tick", 32'(tick), 32'd1);
        cyc(1);
        chk("glitch_leds", 32'(leds), 32'h2);

        // rotate-right
        hard_reset(2'b01);
        step_expect("rotr1", 4'b1000, 4'b0001);
        step_expect("rotr2", 4'b0100, 4'b1000);
        step_expect("rotr3", 4'b0010, 4'b0100);
        step_expect("rotr4", 4'b0001, 4'b0010);

        // bounce
        hard_reset(2'b10);
        step_expect("bnc1", 4'b0010, 4'b0001);
        step_expect("bnc2", 4'b0100, 4'b0010);
        step_expect("bnc3", 4'b1000, 4'b0100);
        step_expect("bnc4", 4'b0100, 4'b1000);
        step_expect("bnc5", 4'b0010, 4'b0100);
        step_expect("bnc6", 4'b0001, 4'b0010);
        step_expect("bnc7", 4'b0010, 4'b0001);

        // rotate into top endpoint, then enter bounce: must turn down
        hard_reset(2'b01);
        step_expect("ent1", 4'b1000, 4'b0001);
        mode = 2'b10;
        step_expect("ent2", 4'b0100, 4'b1000);

        // enable dropped at divider=2 for 10 cycles
        hard_reset(2'b00);
        cyc(2);
        enable = 1'b0;
        cyc(5);
        chk("dis_tick_a", 32'(tick), 32'd0);
        chk("dis_leds_a", 32'(leds), 32'h1);
        cyc(5);
        chk("dis_tick_b", 32'(tick), 32'd0);
        chk("dis_leds_b", 32'(leds), 32'h1);
        enable = 1'b1;
        cyc(1);
        chk("reen_tick", 32'(tick), 32'd1);
        chk("reen_leds0", 32'(leds), 32'h1);
        cyc(1);
        chk("reen_leds", 32'(leds), 32'h2);
        chk("reen_tick0", 32'(tick), 32'd0);

        // hold: mode changed mid-count, divider keeps ticking
        cyc(1);
        mode = 2'b11;
        cyc(2);
        chk("hold_tick", 32'(tick), 32'd1);
        cyc(1);
        chk("hold_leds1", 32'(leds), 32'h2);
        step_expect("hold2", 4'b0010, 4'b0010);
        // reset pulsed while tick is high
        cyc(3);
        chk("pre_rst_tick", 32'(tick), 32'd1);
        hard_reset(2'b00);
        cyc(3);
        chk("post_rst_tick", 32'(tick), 32'd1);
        chk("post_rst_pre", 32'(leds), 32'h1);
        cyc(1);
        chk("post_rst_leds", 32'(leds), 32'h2);

`ifdef LED_CHASER_PWM_EN
        begin
            int on_cnt;
            int nz_cnt;
            mode = 2'b11;
            duty = 4'd4;
            on_cnt = 0;
            repeat (16) begin
                cyc(1);
                if (leds[1]) on_cnt++;
            end
            chk("pwm_duty4", 32'(on_cnt), 32'd4);
            duty = 4'd0;
            nz_cnt = 0;
            repeat (16) begin
                cyc(1);
                if (leds != 4'b0000) nz_cnt++;
            end
            chk("pwm_duty0", 32'(nz_cnt), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
